draw_rect_spans: RTL

- Upstream span scheduler for the 1D horizontal line drawer.
- Takes a rectangle given by two signed corner points, then sorts and clips it to the screen.
- Issues one horizontal span request per row to the downstream 1D drawer, using a start/done handshake.
- Sits between the shape command front-end and the span drawer; it produces filled rectangles.

---
 rtl/draw_rect_spans_pkg.sv | 40 ++++
 rtl/draw_rect_spans.sv | 138 +++++++++++++
 2 files changed

// File: rtl/draw_rect_spans_pkg.sv
// Shared graphics types for draw sequencers: coordinate type, sequencer state
// encoding and the sort/clip helper used for both axes.
package draw_rect_spans_pkg;

  localparam int GFX_CORDW = 16;

  typedef logic signed [GFX_CORDW-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } draw_state_e;

  typedef struct packed {
    coord_t lo;
    coord_t hi;
    logic   empty;
  } span_clip_t;

  localparam coord_t COORD_ZERO = '0;

  // Orders the two endpoints, then clamps them to 0..maxv.
  // The result is flagged empty when the ordered range misses 0..maxv entirely.
  function automatic span_clip_t clamp_span(input coord_t a, input coord_t b,
                                            input coord_t maxv);
    coord_t     lo;
    coord_t     hi;
    span_clip_t r;
    lo      = (a < b) ? a : b;
    hi      = (a < b) ? b : a;
    r.empty = (hi < COORD_ZERO) || (lo > maxv);
    r.lo    = (lo < COORD_ZERO) ? COORD_ZERO : lo;
    r.hi    = (hi > maxv) ? maxv : hi;
    return r;
  endfunction

endpackage

// File: rtl/draw_rect_spans.sv
// Filled-rectangle span scheduler: sorts and clips a rectangle to the screen,
// then hands one horizontal span per row to the downstream 1D drawer.
module draw_rect_spans
  import draw_rect_spans_pkg::*;
#(
  parameter int CORDW = GFX_CORDW,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic                    span_start,
  output logic signed [CORDW-1:0] span_x0,
  output logic signed [CORDW-1:0] span_x1,
  output logic signed [CORDW-1:0] span_y,
  input  logic                    span_done,
  output logic                    busy,
  output logic                    done
);

  localparam coord_t H_MAX = coord_t'(H_RES - 1);
  localparam coord_t V_MAX = coord_t'(V_RES - 1);

  draw_state_e state_q, state_d;
  coord_t      x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  coord_t      cy1_q, cy1_d;
  coord_t      span_x0_q, span_x0_d, span_x1_q, span_x1_d, span_y_q, span_y_d;
  logic        span_start_q, span_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  span_clip_t  x_clip, y_clip;

  assign x_clip = clamp_span(x0_q, x1_q, H_MAX);
  assign y_clip = clamp_span(y0_q, y1_q, V_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      cy1_q        <= '0;
      span_x0_q    <= '0;
      span_x1_q    <= '0;
      span_y_q     <= '0;
      span_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      cy1_q        <= cy1_d;
      span_x0_q    <= span_x0_d;
      span_x1_q    <= span_x1_d;
      span_y_q     <= span_y_d;
      span_start_q <= span_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Pulse outputs are decoded on the transition so they appear registered
  // in the cycle the FSM enters ISSUE or DONE.
  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    cy1_d        = cy1_q;
    span_x0_d    = span_x0_q;
    span_x1_d    = span_x1_q;
    span_y_d     = span_y_q;
    span_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          busy_d  = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        if (x_clip.empty || y_clip.empty) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          span_x0_d    = x_clip.lo;
          span_x1_d    = x_clip.hi;
          span_y_d     = y_clip.lo;
          cy1_d        = y_clip.hi;
          span_start_d = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (span_done) begin
          if (span_y_q == cy1_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            span_y_d     = span_y_q + coord_t'(1);
            span_start_d = 1'b1;
            state_d      = ST_ISSUE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign span_start = span_start_q;
  assign span_x0    = span_x0_q;
  assign span_x1    = span_x1_q;
  assign span_y     = span_y_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
